// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control unit (Moore FSM with memory handshake)
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   OP[5:0]            : opcode from the instruction register, consumed in DECODE
//   mem_ready          : memory access completes this cycle (FETCH, MEM_RD, MEM_WR only)
//   PCWrite .. ALUSrcA : 1-bit datapath strobes and mux selects
//   PCSource, ALUSrcB  : 2-bit mux selects
//   ALUOp[2:0]         : ALU control code
//   illegal_op         : pulse while DECODE sees an unsupported opcode
//   instr_count[31:0]  : retired instruction count, wraps
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OP,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNE,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        Lui,
    output logic        ALUSrcA,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, I_EXEC, I_WB, LUI_WB, BRANCH, JUMP
    } state_t;

    state_t      state;
    state_t      nextState;
    state_t      outState;
    logic [5:0]  opReg;
    logic [31:0] instrCount;
    logic        retire;

    assign instr_count = instrCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            opReg      <= 6'h00;
            instrCount <= 32'd0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                opReg <= OP;
            end
            if (retire) begin
                instrCount <= instrCount + 32'd1;
            end
        end
    end

    // Outputs are decoded from FETCH while reset is held, so an in-flight
    // MEM_WR cannot emit a write strobe in the reset cycle.
    always_comb begin
        outState    = reset ? FETCH : state;
        nextState   = state;
        retire      = 1'b0;
        illegal_op  = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Lui         = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;

        case (outState)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b100;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b100;
                case (OP)
                    OP_RTYPE:        nextState = R_EXEC;
                    OP_ADDI, OP_ORI: nextState = I_EXEC;
                    OP_LUI:          nextState = LUI_WB;
                    OP_LW, OP_SW:    nextState = MEM_ADDR;
                    OP_BEQ, OP_BNE:  nextState = BRANCH;
                    OP_J:            nextState = JUMP;
                    default: begin
                        nextState  = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = 3'b100;
                nextState = (opReg == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nextState = MEM_WB;
                end
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            MEM_WR: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    MemWrite  = 1'b1;
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            R_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 3'b111;
                nextState = R_WB;
            end
            R_WB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            I_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = (opReg == OP_ORI) ? 3'b101 : 3'b100;
                nextState = I_WB;
            end
            I_WB: begin
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            LUI_WB: begin
                Lui       = 1'b1;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b010;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (opReg == OP_BNE);
                retire      = 1'b1;
                nextState   = FETCH;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                retire    = 1'b1;
                nextState = FETCH;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

endmodule
